// File: rtl/eeg_pea_out_col.sv
// Output collector: round-robin arbiter over all PE output channels feeding one
// registered output-RAM write port. Define EEG_PEA_OCOL_CNT_EN to add the WR_CNT write counter.
module eeg_pea_ocol_lane #(
  parameter int LANE = 0,
  parameter int AW   = 10,
  parameter int IAW  = 8
) (
  input  logic [AW-1:0]  base_i,
  input  logic [AW-1:0]  str_i,
  input  logic [IAW-1:0] add_i,
  output logic [AW-1:0]  add_o
);
  localparam logic [AW-1:0] LOFF = AW'(LANE);

  // Lane offset is a constant multiple of the stride; the sum wraps modulo 2^AW.
  assign add_o = base_i + LOFF * str_i + AW'(add_i);
endmodule

module eeg_pea_out_col #(
  parameter int PE_ROW      = 4,
  parameter int PE_COL      = 4,
  parameter int DATA_OUT_DW = 8,
  parameter int OMUX_ADD_AW = 8,
  parameter int ORAM_ADD_AW = 10
) (
  input  logic                                                  clk,
  input  logic                                                  rst_n,
  input  logic                                                  START,
  input  logic [ORAM_ADD_AW-1:0]                                CFG_OUT_BASE,
  input  logic [ORAM_ADD_AW-1:0]                                CFG_OUT_STR,
  input  logic [PE_COL-1:0][PE_ROW-1:0]                         IN_VLD,
  output logic [PE_COL-1:0][PE_ROW-1:0]                         IN_RDY,
  input  logic [PE_COL-1:0][PE_ROW-1:0]                         IN_LST,
  input  logic [PE_COL-1:0][PE_ROW-1:0][DATA_OUT_DW-1:0]        IN_DAT,
  input  logic [PE_COL-1:0][PE_ROW-1:0][OMUX_ADD_AW-1:0]        IN_ADD,
  output logic                                                  ORAM_WEN,
  input  logic                                                  ORAM_RDY,
  output logic [ORAM_ADD_AW-1:0]                                ORAM_ADD,
  output logic [DATA_OUT_DW-1:0]                                ORAM_DAT,
  output logic                                                  IS_IDLE,
  output logic                                                  DONE
`ifdef EEG_PEA_OCOL_CNT_EN
  ,
  output logic [ORAM_ADD_AW:0]                                  WR_CNT
`endif
);
  localparam int N  = PE_COL * PE_ROW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t                              state_q;
  logic [ORAM_ADD_AW-1:0]              base_q, str_q, add_q, add_d;
  logic [DATA_OUT_DW-1:0]              dat_q, dat_d;
  logic [N-1:0]                        seen_q, vld_f, lst_f, elig, rdy_f;
  logic [N-1:0][DATA_OUT_DW-1:0]       dat_f;
  logic [N-1:0][OMUX_ADD_AW-1:0]       add_f;
  logic [N-1:0][ORAM_ADD_AW-1:0]       lane_add;
  logic [CW-1:0]                       ptr_q, ptr_d, gnt_ch;
  logic                                gnt_vld, space, acc, wen_q, done_q, idle_q;

  // Packed [col][row] flattens to ch = col*PE_ROW + row.
  assign vld_f = IN_VLD;
  assign lst_f = IN_LST;
  assign dat_f = IN_DAT;
  assign add_f = IN_ADD;

  assign elig = (state_q == S_RUN) ? (vld_f & ~seen_q) : '0;

  // Scan from the farthest offset down so the nearest eligible channel at/after ptr wins.
  always_comb begin
    int j;
    logic [CW-1:0] idx;
    gnt_vld = 1'b0;
    gnt_ch  = '0;
    for (int i = N-1; i >= 0; i--) begin
      j = int'(ptr_q) + i;
      if (j >= N) j = j - N;
      idx = CW'(j);
      if (elig[idx]) begin
        gnt_vld = 1'b1;
        gnt_ch  = idx;
      end
    end
  end

  assign space = ~wen_q | ORAM_RDY;
  assign acc   = gnt_vld & space;

  always_comb begin
    rdy_f = '0;
    if (acc) rdy_f[gnt_ch] = 1'b1;
  end
  assign IN_RDY = rdy_f;

  for (genvar g = 0; g < N; g++) begin : g_lane
    eeg_pea_ocol_lane #(.LANE(g), .AW(ORAM_ADD_AW), .IAW(OMUX_ADD_AW)) u_lane (
      .base_i (base_q),
      .str_i  (str_q),
      .add_i  (add_f[g]),
      .add_o  (lane_add[g])
    );
  end

  assign add_d = lane_add[gnt_ch];
  assign dat_d = dat_f[gnt_ch];
  assign ptr_d = (gnt_ch == CW'(N-1)) ? '0 : gnt_ch + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      str_q   <= '0;
      seen_q  <= '0;
      ptr_q   <= '0;
      wen_q   <= 1'b0;
      add_q   <= '0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (START) begin
          state_q <= S_RUN;
          base_q  <= CFG_OUT_BASE;
          str_q   <= CFG_OUT_STR;
          seen_q  <= '0;
          ptr_q   <= '0;
          idle_q  <= 1'b0;
        end
        S_RUN: if (&seen_q && space) begin
          state_q <= S_FIN;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          idle_q  <= 1'b1;
        end
      endcase
      if (acc) begin
        wen_q <= 1'b1;
        add_q <= add_d;
        dat_q <= dat_d;
        ptr_q <= ptr_d;
        if (lst_f[gnt_ch]) seen_q[gnt_ch] <= 1'b1;
      end else if (ORAM_RDY) begin
        wen_q <= 1'b0;
      end
    end
  end

  assign ORAM_WEN = wen_q;
  assign ORAM_ADD = add_q;
  assign ORAM_DAT = dat_q;
  assign DONE     = done_q;
  assign IS_IDLE  = idle_q;

`ifdef EEG_PEA_OCOL_CNT_EN
  logic [ORAM_ADD_AW:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              cnt_q <= '0;
    else if (state_q == S_IDLE && START)     cnt_q <= '0;
    else if (wen_q && ORAM_RDY && ~&cnt_q)   cnt_q <= cnt_q + 1'b1;
  end
  assign WR_CNT = cnt_q;
`endif
endmodule

// File: doc/eeg_pea_out_col.md
# eeg_pea_out_col

Output collector for the PE-array engine: the receiving end of its per-PE output stream (`OUT_VLD/OUT_LST/OUT_DAT/OUT_ADD`, `OUT_RDY`). It arbitrates round-robin among all `PE_COL*PE_ROW` PE output channels and writes one result per cycle into the output RAM through a single registered write port with back-pressure. It tracks each channel's last-beat marker and reports completion of a convolution pass to the layer controller.

## Interface

Parameters:
- `PE_ROW`, 4, PE rows.
- `PE_COL`, 4, PE columns; channel index `ch = col*PE_ROW + row`, `N = PE_COL*PE_ROW`.
- `DATA_OUT_DW`, 8, result width.
- `OMUX_ADD_AW`, 8, per-PE local output address width.
- `ORAM_ADD_AW`, 10, output RAM address width.

Ports:
- `clk`, in, 1, the block's only clock.
- `rst_n`, in, 1, reset; asynchronous, active-low.
- `START`, in, 1, single-cycle pulse that begins a pass; honoured only in IDLE.
- `CFG_OUT_BASE`, in, `ORAM_ADD_AW`, base RAM address of the pass; sampled on START.
- `CFG_OUT_STR`, in, `ORAM_ADD_AW`, per-channel address stride; sampled on START.
- `IN_VLD`, in, `[PE_COL][PE_ROW]`, per-PE result valid.
- `IN_RDY`, out, `[PE_COL][PE_ROW]`, per-PE ready.
- `IN_LST`, in, `[PE_COL][PE_ROW]`, final result of this PE for the pass.
- `IN_DAT`, in, `[PE_COL][PE_ROW][DATA_OUT_DW]`, result data.
- `IN_ADD`, in, `[PE_COL][PE_ROW][OMUX_ADD_AW]`, PE-local output address.
- `ORAM_WEN`, out, 1, RAM write valid.
- `ORAM_RDY`, in, 1, RAM accepts the write this cycle.
- `ORAM_ADD`, out, `ORAM_ADD_AW`, RAM write address.
- `ORAM_DAT`, out, `DATA_OUT_DW`, RAM write data.
- `IS_IDLE`, out, 1, high in IDLE.
- `DONE`, out, 1, one-cycle pulse at pass completion.

## Operation

- FSM states: IDLE → RUN on START. RUN → FIN when `lst_seen` is all ones and the output register is empty (or drains this cycle). FIN → IDLE unconditionally after one cycle; `DONE=1` in FIN.
- On START: latch `base` and `str`, clear `lst_seen[N-1:0]`, set the RR pointer `ptr=0`.
- Eligible channels: `IN_VLD[ch] & ~lst_seen[ch]`, RUN state only.
- Grant: the first eligible channel at or after `ptr`, scanning upward modulo N. At most one grant per cycle.
- `IN_RDY[ch] = RUN & grant==ch & (~ORAM_WEN | ORAM_RDY)`. Every other ready is 0; in IDLE and FIN all are 0.
- On accept (`IN_VLD & IN_RDY`) of channel `ch`:
  - load the output register with `ORAM_ADD = base + ch*str + zero-extended IN_ADD`, computed modulo `2^ORAM_ADD_AW` (wrap, no error);
  - `ORAM_DAT = IN_DAT`;
  - `ptr = (ch+1) mod N`;
  - if `IN_LST`, set `lst_seen[ch]`.
- Output register:
  - holds its contents while `ORAM_WEN & ~ORAM_RDY`;
  - clears `ORAM_WEN` on `ORAM_RDY` when there is no new accept;
  - a new accept in the same cycle as `ORAM_RDY` reloads it back-to-back.
- Once a channel's `lst_seen` bit is set, it gets no further grants until the next START.
- START outside IDLE is ignored.
- `ptr` is unchanged in cycles with no grant.

## Timing

- Reset values: `IN_RDY=0`, `ORAM_WEN=0`, `ORAM_ADD=0`, `ORAM_DAT=0`, `DONE=0`, `IS_IDLE=1`; state IDLE, `lst_seen=0`, `ptr=0`.
- Latency: accept at cycle t → `ORAM_WEN=1` with the data at t+1.
- Throughput: 1 write per cycle while `ORAM_RDY=1`.
- Readies are combinational from `IN_VLD`, `ptr`, `lst_seen`, `ORAM_WEN` and `ORAM_RDY`. There is no combinational path from `IN_DAT` or `IN_ADD` to any output.
- `DONE` asserts the cycle after the last RAM write completes. The earliest case is last accept at t, `ORAM_RDY=1` at t+1, `DONE` at t+2.
- `rst_n` low mid-pass: everything returns to reset values immediately; any pending write is dropped.

## Configuration

- `EEG_PEA_OCOL_CNT_EN`: when defined, adds an output port `WR_CNT` (`ORAM_ADD_AW+1` bits).
  - Cleared on START.
  - Incremented on each completed RAM write (`ORAM_WEN & ORAM_RDY`).
  - Saturates at all-ones.
  - Holds its value after DONE until the next START.
- When not defined, the port and the counter are absent and behaviour is otherwise identical.

## Test plan

- Reset, then START with base=0x100, str=0x10; only ch5 valid with `IN_ADD=3`, `IN_DAT=0x7F`, `IN_LST=0`. Expect `ORAM_WEN` one cycle later with `ADD=0x153`, `DAT=0x7F`.
- All 16 channels continuously valid, `ORAM_RDY=1`. Expect grants in the order 0,1,…,15,0 and 16 consecutive writes with no bubbles.
- Hold `ORAM_RDY=0` for 3 cycles during streaming. Expect `ORAM_WEN`/`ADD`/`DAT` held stable, all `IN_RDY=0`, and no data lost or duplicated afterwards.
- Each channel sends 2 beats, the second with `IN_LST=1`. Expect 32 writes, `DONE` pulsing exactly once one cycle after the 32nd write handshake, then `IS_IDLE=1`. With the macro defined, `WR_CNT=32`.
- base=0x3F0, str=0x10, ch15, `IN_ADD=0x20`. Expect the address to wrap to `(0x3F0+0xF0+0x20) mod 0x400 = 0x100`.
- Assert `rst_n` low mid-pass with `ORAM_WEN=1`. Expect outputs at reset values immediately; a following START runs a clean pass with `ptr` back at 0.
